// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command sequencer for the TinyALU. Operations arrive over a valid/ready
// command port and are buffered in a small FIFO. The sequencer drives the
// ALU start/op/operand/reset pins one operation at a time and returns each
// result, or a timeout indication, over a valid/ready response port.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op       command operands and opcode
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_op         captured ALU result and the op that produced it
//   rsp_timeout                ALU never signalled done; rsp_result is 0
//   alu_a, alu_b, alu_op       operands and opcode presented to the ALU
//   alu_start, alu_reset_n     ALU start and active-low reset
//   alu_done, alu_result       ALU completion flag and result

module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [2:0]          cmd_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [2:0]          rsp_op,
  output logic                rsp_timeout,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  output logic                alu_reset_n,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = 2 * DATA_W + 3;

  typedef enum logic [2:0] {IDLE, BUSY, NOP, RST, RESP} state_t;

  state_t state, state_nxt;

  // FIFO storage; each entry is {op, a, b}
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;

  logic [CW-1:0]       cnt, cnt_nxt;
  logic [DATA_W-1:0]   a_nxt, b_nxt;
  logic [2:0]          op_nxt, rop_nxt;
  logic                start_nxt, rstn_nxt, valid_nxt, tmo_nxt;
  logic [2*DATA_W-1:0] result_nxt;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      alu_a       <= a_nxt;
      alu_b       <= b_nxt;
      alu_op      <= op_nxt;
      alu_start   <= start_nxt;
      alu_reset_n <= rstn_nxt;
      rsp_valid   <= valid_nxt;
      rsp_result  <= result_nxt;
      rsp_op      <= rop_nxt;
      rsp_timeout <= tmo_nxt;
    end
  end

  // Outputs are registered; this block computes their next values so that
  // alu_reset_n defaults high and only the RST entry pulls it low.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    cnt_nxt    = cnt;
    a_nxt      = alu_a;
    b_nxt      = alu_b;
    op_nxt     = alu_op;
    start_nxt  = alu_start;
    rstn_nxt   = 1'b1;
    valid_nxt  = rsp_valid;
    result_nxt = rsp_result;
    rop_nxt    = rsp_op;
    tmo_nxt    = rsp_timeout;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          op_nxt  = head[EW-1 -: 3];
          a_nxt   = head[2*DATA_W-1 -: DATA_W];
          b_nxt   = head[DATA_W-1:0];
          cnt_nxt = '0;
          case (head[EW-1 -: 3])
            3'b001, 3'b010, 3'b011, 3'b100: begin
              state_nxt = BUSY;
              start_nxt = 1'b1;
            end
            3'b111: begin
              state_nxt = RST;
              start_nxt = 1'b0;
              rstn_nxt  = 1'b0;
            end
            // 000 and the unused codes 101/110 all behave as no_op
            default: begin
              state_nxt = NOP;
              start_nxt = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        // A done arriving on the final allowed cycle still wins over timeout
        if (alu_done) begin
          state_nxt  = RESP;
          start_nxt  = 1'b0;
          valid_nxt  = 1'b1;
          result_nxt = alu_result;
          rop_nxt    = alu_op;
          tmo_nxt    = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt  = RESP;
          start_nxt  = 1'b0;
          valid_nxt  = 1'b1;
          result_nxt = '0;
          rop_nxt    = alu_op;
          tmo_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      NOP: begin
        start_nxt = 1'b0;
        state_nxt = IDLE;
      end
      RST: begin
        state_nxt = IDLE;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
